data_mem_responder: RTL

Responder end of the pipeline's data-memory interface: it services the load/store requests raised by the memory stage (mem_read / mem_write with address and store data) and returns load data a fixed number of wait states later. While an access is in flight it holds the pipeline with `stall`, and it signals completion with a one-cycle `ready`. It sits between the memory stage and the writeback stage and replaces the single-cycle data array with a multi-cycle, stall-aware word memory.

---
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// Purpose : multi-cycle, stall-aware data-memory responder for the pipeline memory stage.
// Latency : LATENCY+1 cycles from an accepted request to the one-cycle ready pulse; errors complete in 1.
// Backpressure: stall holds the pipeline while a request is pending; requests seen in DONE are ignored.
//
// Ports:
//   clk, rst_n             clock and synchronous active-low reset
//   mem_read, mem_write    load / store request from the memory stage
//   addr, write_data       byte address and store data, latched when the request is accepted
//   read_data              load data, valid while ready=1 for a load (0 otherwise)
//   ready                  registered one-cycle completion pulse
//   stall                  combinational hold request (state + request inputs)
//   addr_err               registered; flags an errored completion, valid with ready
module data_mem_responder #(
   parameter int unsigned DEPTH   = 256,
   parameter int unsigned LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic        stall,
   output logic        addr_err
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          op_wr_q, op_wr_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   read_data_q, read_data_d;
   logic          ready_q, ready_d;
   logic          addr_err_q, addr_err_d;

   logic [31:0]   mem [DEPTH];

   logic          req;
   logic          req_err;
   logic          mem_we;

   assign req = mem_read | mem_write;

   // Misaligned, beyond the array, or an ambiguous read+write request.
   assign req_err = (addr[1:0] != 2'b00)
                  | (addr[31:AW+2] != '0)
                  | (mem_read & mem_write);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      op_wr_d     = op_wr_q;
      idx_d       = idx_q;
      wdata_d     = wdata_q;
      // Completion outputs live for exactly the DONE cycle, so they default low.
      ready_d     = 1'b0;
      addr_err_d  = 1'b0;
      read_data_d = '0;
      mem_we      = 1'b0;
      stall       = 1'b0;

      case (state_q)
         IDLE: begin
            stall = req;
            if (req) begin
               if (req_err) begin
                  state_d    = DONE;
                  ready_d    = 1'b1;
                  addr_err_d = 1'b1;
               end else begin
                  state_d = BUSY;
                  op_wr_d = mem_write;
                  idx_d   = addr[AW+1:2];
                  wdata_d = write_data;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end

         BUSY: begin
            stall = 1'b1;
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               // Final wait state: the access happens on this edge.
               state_d = DONE;
               ready_d = 1'b1;
               if (op_wr_q) begin
                  mem_we = 1'b1;
               end else begin
                  read_data_d = mem[idx_q];
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         op_wr_q     <= 1'b0;
         idx_q       <= '0;
         wdata_q     <= '0;
         read_data_q <= '0;
         ready_q     <= 1'b0;
         addr_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         op_wr_q     <= op_wr_d;
         idx_q       <= idx_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
         ready_q     <= ready_d;
         addr_err_q  <= addr_err_d;
      end
   end

   // Storage is never cleared; a reset on the final BUSY edge drops the pending store.
   always_ff @(posedge clk) begin
      if (rst_n && mem_we) begin
         mem[idx_q] <= wdata_q;
      end
   end

   assign read_data = read_data_q;
   assign ready     = ready_q;
   assign addr_err  = addr_err_q;

endmodule
